// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and instruction field positions for the stall controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MEM_WAIT, HUNG} state_e;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: hazard inputs and pipeline enables between the datapath and the stall controller
interface pipeline_stall_ctrl_if #(parameter int CNT_W = 16);
    logic             IDEX_MemRead_i;
    logic [4:0]       IDEX_RegisterRt_i;
    logic [31:0]      instr_i;
    logic             branch_taken_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IFIDFlush_o;
    logic             IDEXBubble_o;
    logic             pipe_hold_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    modport master (
        output IDEX_MemRead_i, IDEX_RegisterRt_i, instr_i, branch_taken_i, mem_req_i, mem_ack_i,
        input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, pipe_hold_o, timeout_o, stall_cnt_o
    );
    modport slave (
        input  IDEX_MemRead_i, IDEX_RegisterRt_i, instr_i, branch_taken_i, mem_req_i, mem_ack_i,
        output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o, pipe_hold_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a load in EX is about to write
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_RegisterRt,
    input  logic [31:0] instr,
    output logic        lu
);
    logic unused_bits;
    assign unused_bits = ^{instr[31:26], instr[15:0]};
    // r0 is hardwired to zero, so a load into it never creates a hazard
    assign lu = IDEX_MemRead && IDEX_RegisterRt != 5'd0 &&
                (IDEX_RegisterRt == instr[RS_MSB:RS_LSB] || IDEX_RegisterRt == instr[RT_MSB:RT_LSB]);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: merges memory-wait, load-use and branch hazards into pipeline enables
// with a memory watchdog and a saturating stall counter
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    pipeline_stall_ctrl_if.slave bus
);
    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lu;
    logic              mem_hold;
    logic              run_ok;
    load_use_detect u_lud (
        .IDEX_MemRead    (bus.IDEX_MemRead_i),
        .IDEX_RegisterRt (bus.IDEX_RegisterRt_i),
        .instr           (bus.instr_i),
        .lu              (lu)
    );
    // an ack releases the hold in the same cycle, letting ID hazards be judged immediately
    assign mem_hold = (state == MEM_WAIT) ? !bus.mem_ack_i
                                          : state == RUN && bus.mem_req_i && !bus.mem_ack_i;
    assign run_ok            = !rst_i && state != HUNG && !mem_hold;
    assign bus.PCWrite_o     = run_ok && !lu;
    assign bus.IFIDWrite_o   = run_ok && !lu;
    assign bus.IFIDFlush_o   = run_ok && !lu && bus.branch_taken_i;
    assign bus.IDEXBubble_o  = rst_i || (run_ok && lu);
    assign bus.pipe_hold_o   = !run_ok;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= RUN;
            wait_cnt        <= '0;
            bus.timeout_o   <= 1'b0;
            bus.stall_cnt_o <= '0;
        end else begin
            if (!bus.PCWrite_o && bus.stall_cnt_o != '1)
                bus.stall_cnt_o <= bus.stall_cnt_o + 1'b1;
            if (state == RUN && mem_hold) begin
                state    <= MEM_WAIT;
                wait_cnt <= WAIT_W'(1);
            end else if (state == MEM_WAIT) begin
                if (bus.mem_ack_i) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                    state         <= HUNG;
                    bus.timeout_o <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed stimulus checked against a behavioural hazard model every cycle
module tb_pipeline_stall_ctrl;
    localparam int MAXW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   m_n = 0;
    logic m_hung = 1'b0;
    logic m_to = 1'b0;
    logic [15:0] m_cnt = '0;
    pipeline_stall_ctrl_if #(.CNT_W(16)) bus ();
    pipeline_stall_ctrl #(.CNT_W(16), .MAX_WAIT(MAXW), .WAIT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
        end
    endtask
    function automatic logic m_lu();
        logic [31:0] ins = bus.instr_i;
        return bus.IDEX_MemRead_i && bus.IDEX_RegisterRt_i != 0 &&
               (bus.IDEX_RegisterRt_i == ins[25:21] || bus.IDEX_RegisterRt_i == ins[20:16]);
    endfunction
    // memory is blocking either as a fresh request or while a wait is outstanding
    function automatic logic m_mem_stall();
        if (m_hung) return 1'b0;
        return (m_n > 0) ? !bus.mem_ack_i : (bus.mem_req_i && !bus.mem_ack_i);
    endfunction
    function automatic logic m_pc();
        return !rst && !m_hung && !m_mem_stall() && !m_lu();
    endfunction
    // {PCWrite, IFIDWrite, Flush, Bubble, hold}
    function automatic logic [4:0] model_out();
        if (rst) return 5'b00011;
        if (m_hung || m_mem_stall()) return 5'b00001;
        if (m_lu()) return 5'b00010;
        return {2'b11, bus.branch_taken_i, 2'b00};
    endfunction
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_hung <= 1'b0; m_to <= 1'b0; m_cnt <= '0;
        end else begin
            if (!m_pc() && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (!m_hung) begin
                if (m_mem_stall()) begin
                    m_n <= m_n + 1;
                    if (m_n + 1 == MAXW + 1) begin
                        m_hung <= 1'b1; m_to <= 1'b1;
                    end
                end else m_n <= 0;
            end
        end
    end
    always @(negedge clk) begin
        chk("outs", {27'd0, bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o, bus.IDEXBubble_o, bus.pipe_hold_o},
            {27'd0, model_out()});
        chk("timeout", {31'd0, bus.timeout_o}, {31'd0, m_to});
        chk("stall_cnt", {16'd0, bus.stall_cnt_o}, {16'd0, m_cnt});
    end
    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, 16'd0};
    endfunction
    task automatic drive(input logic mr, input logic [4:0] rt, input logic [31:0] ins,
                         input logic br, input logic req, input logic ack);
        bus.IDEX_MemRead_i = mr; bus.IDEX_RegisterRt_i = rt; bus.instr_i = ins;
        bus.branch_taken_i = br; bus.mem_req_i = req; bus.mem_ack_i = ack;
        #2;
    endtask
    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic idle();
        drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        idle();
        repeat (3) tick();
        chk("rst_bubble", {31'd0, bus.IDEXBubble_o}, 32'd1);
        rst = 1'b0;
        repeat (10) begin idle(); tick(); end
        chk("idle_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
        drive(1'b1, 5'd8, mk(5'd8, 5'd3), 1'b0, 1'b0, 1'b0);
        chk("lu_pc", {31'd0, bus.PCWrite_o}, 32'd0);
        chk("lu_bubble", {31'd0, bus.IDEXBubble_o}, 32'd1);
        tick();
        idle();
        chk("lu_after_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        tick();
        chk("lu_cnt", {16'd0, bus.stall_cnt_o}, 32'd1);
        drive(1'b1, 5'd0, mk(5'd0, 5'd7), 1'b0, 1'b0, 1'b0);
        chk("r0_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        tick();
        drive(1'b1, 5'd5, mk(5'd3, 5'd4), 1'b0, 1'b0, 1'b0);
        chk("nomatch_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        tick();
        repeat (3) begin
            drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b1, 1'b0);
            chk("mw_hold", {31'd0, bus.pipe_hold_o}, 32'd1);
            tick();
        end
        drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b1, 1'b1);
        chk("ack_hold", {31'd0, bus.pipe_hold_o}, 32'd0);
        chk("ack_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        tick();
        chk("mw_cnt", {16'd0, bus.stall_cnt_o}, 32'd4);
        drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b1, 1'b1);
        chk("reqack_hold", {31'd0, bus.pipe_hold_o}, 32'd0);
        tick();
        drive(1'b1, 5'd8, mk(5'd8, 5'd3), 1'b1, 1'b0, 1'b0);
        chk("lubr_flush", {31'd0, bus.IFIDFlush_o}, 32'd0);
        chk("lubr_pc", {31'd0, bus.PCWrite_o}, 32'd0);
        tick();
        drive(1'b0, 5'd0, mk(5'd8, 5'd3), 1'b1, 1'b0, 1'b0);
        chk("br_flush", {31'd0, bus.IFIDFlush_o}, 32'd1);
        chk("br_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        tick();
        chk("br_cnt", {16'd0, bus.stall_cnt_o}, 32'd5);
        repeat (4) begin
            drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("pre_hang_to", {31'd0, bus.timeout_o}, 32'd0);
        tick();
        chk("hang_to", {31'd0, bus.timeout_o}, 32'd1);
        drive(1'b0, 5'd0, mk(5'd1, 5'd2), 1'b0, 1'b1, 1'b1);
        chk("hung_ack_hold", {31'd0, bus.pipe_hold_o}, 32'd1);
        repeat (3) tick();
        chk("hung_sticky", {31'd0, bus.timeout_o}, 32'd1);
        chk("hung_cnt", {16'd0, bus.stall_cnt_o}, 32'd13);
        #2 rst = 1'b1;
        #1;
        chk("arst_to", {31'd0, bus.timeout_o}, 32'd0);
        chk("arst_cnt", {16'd0, bus.stall_cnt_o}, 32'd0);
        chk("arst_bubble", {31'd0, bus.IDEXBubble_o}, 32'd1);
        tick();
        idle();
        tick();
        rst = 1'b0;
        repeat (3) begin idle(); tick(); end
        chk("post_pc", {31'd0, bus.PCWrite_o}, 32'd1);
        chk("post_to", {31'd0, bus.timeout_o}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
